// File: rtl/wb_stage_pkg.sv
// Shared writeback encodings: result-select codes, load funct3 codes, default widths.
package wb_stage_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {
    WBSEL_ALU  = 2'b00,
    WBSEL_LOAD = 2'b01,
    WBSEL_PC4  = 2'b10,
    WBSEL_RSVD = 2'b11
  } wbsel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_align.sv
// load_align: picks the byte/half/word addressed by offset out of a memory
// word and sign- or zero-extends it according to the load funct3.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[8*offset +: 8];
  assign h = offset[1] ? rdata[31:16] : rdata[15:0];

  // Size/sign select; unknown codes behave as a full-word load.
  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{b[7]}}, b};
      F3_LBU:  result = {24'd0, b};
      F3_LH:   result = {{16{h[15]}}, h};
      F3_LHU:  result = {16'd0, h};
      default: result = rdata;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback register feeding the register file write port, with
// load alignment and an optional decode bypass (macro WB_BYPASS_EN).
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     ex_valid,
  input  logic                     ex_regwrite,
  input  logic [$clog2(NREGS)-1:0] ex_rd,
  input  logic [1:0]               ex_wbsel,
  input  logic [XLEN-1:0]          ex_alu,
  input  logic [XLEN-1:0]          ex_pc4,
  input  logic [2:0]               ex_funct3,
  input  logic [XLEN-1:0]          dmem_rdata,
  input  logic [$clog2(NREGS)-1:0] id_ra1,
  input  logic [$clog2(NREGS)-1:0] id_ra2,
  input  logic [XLEN-1:0]          rf_rd1,
  input  logic [XLEN-1:0]          rf_rd2,
  output logic                     rf_we,
  output logic [$clog2(NREGS)-1:0] rf_wa,
  output logic [XLEN-1:0]          rf_wd,
  output logic [XLEN-1:0]          fwd_rd1,
  output logic [XLEN-1:0]          fwd_rd2,
  output logic                     wb_retire
);
  localparam int RW = $clog2(NREGS);

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic [RW-1:0]   rd;
    wbsel_e          wbsel;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu;   // alu[1:0] doubles as the load byte offset
    logic [XLEN-1:0] pc4;
  } wb_req_t;

  wb_req_t     st;
  logic        done;   // held instruction already wrote/retired
  logic [31:0] ld_data;

  // Stage register: capture when not stalled; while stalled, remember that
  // the held instruction has had its single write so it is not repeated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= '0;
      done <= 1'b0;
    end else if (!stall) begin
      st.valid    <= ex_valid & ~flush;
      st.regwrite <= ex_regwrite;
      st.rd       <= ex_rd;
      st.wbsel    <= wbsel_e'(ex_wbsel);
      st.funct3   <= ex_funct3;
      st.alu      <= ex_alu;
      st.pc4      <= ex_pc4;
      done        <= 1'b0;
    end else if (st.valid) begin
      done <= 1'b1;
    end
  end

  load_align u_align (
    .rdata  (dmem_rdata),
    .offset (st.alu[1:0]),
    .funct3 (st.funct3),
    .result (ld_data)
  );

  assign wb_retire = st.valid & ~done;
  assign rf_we     = wb_retire & st.regwrite & (st.rd != '0);
  assign rf_wa     = st.rd;

  // Result select; the reserved code falls back to the ALU result.
  always_comb begin
    rf_wd = st.alu;
    case (st.wbsel)
      WBSEL_LOAD: rf_wd = ld_data;
      WBSEL_PC4:  rf_wd = st.pc4;
      default:    rf_wd = st.alu;
    endcase
  end

`ifdef WB_BYPASS_EN
  assign fwd_rd1 = (rf_we && rf_wa == id_ra1 && id_ra1 != '0) ? rf_wd : rf_rd1;
  assign fwd_rd2 = (rf_we && rf_wa == id_ra2 && id_ra2 != '0) ? rf_wd : rf_rd2;
`else
  // No bypass: hazard unit covers read-after-write with an extra stall.
  logic unused_ra;
  assign unused_ra = ^{id_ra1, id_ra2};
  assign fwd_rd1   = rf_rd1;
  assign fwd_rd2   = rf_rd2;
`endif
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback pipeline stage that sits directly upstream of the 32x32 register file.
- Captures execute-stage results and aligns/extends load data returning from synchronous data memory.
- Drives the register file write port (we/wa/wd) with exactly one write per retired instruction.
- Provides decode-stage bypass of the in-flight writeback value onto the register file's asynchronous read data.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural registers; index width is log2(NREGS) = 5

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
stall  input  1  hold stage register; no new capture
flush  input  1  kill the instruction being captured this cycle
ex_valid  input  1  execute stage holds a real instruction
ex_regwrite  input  1  instruction writes rd
ex_rd  input  5  destination register
ex_wbsel  input  2  00 ALU result, 01 load data, 10 PC+4, 11 reserved (treated as 00)
ex_alu  input  32  ALU result; bits [1:0] are the load byte offset
ex_pc4  input  32  PC+4 for jal/jalr
ex_funct3  input  3  load size/sign
dmem_rdata  input  32  synchronous memory read word; valid the cycle after ex capture
id_ra1, id_ra2  input  5  decode read addresses, same as register file ra1/ra2
rf_rd1, rf_rd2  input  32  register file read data
rf_we  output  1  register file write enable
rf_wa  output  5  register file write address
rf_wd  output  32  register file write data
fwd_rd1, fwd_rd2  output  32  bypassed operands to decode
wb_retire  output  1  one-cycle pulse per retired instruction

Behaviour:
- Async reset clears all stage state. Output values while rst is asserted:
  - rf_we=0, rf_wa=0, wb_retire=0.
  - rf_wd=0 (held stage state is cleared; rf_wd is a function of that state).
  - fwd_rd1/fwd_rd2 = rf_rd1/rf_rd2 (bypass inactive while stage invalid).
- Reset mid-operation discards the held instruction; no write occurs.
- Capture at posedge when !stall:
  - valid <= ex_valid & !flush.
  - rd, regwrite, wbsel, funct3, offset, alu and pc4 are registered.
- Stall held: the register retains its contents. flush is ignored while stall=1; stall has priority.
- Done flag:
  - Set at the edge the held instruction writes.
  - Cleared on every capture.
  - Guarantees one write and one wb_retire pulse per instruction even across multi-cycle stalls.
- rf_we = valid & regwrite & !done & (rd != 0). Writes to x0 are suppressed here as well as in the register file.
- wb_retire = valid & !done, independent of regwrite.
- rf_wa = held rd.
- rf_wd mux selection: wbsel 00/11 -> alu; 01 -> aligned load; 10 -> pc4.
- Load alignment uses dmem_rdata with the held offset:
  - funct3 000 lb: byte[offset], sign-extend.
  - 100 lbu: byte[offset], zero-extend.
  - 001 lh: half[offset[1]], sign-extend.
  - 101 lhu: half[offset[1]], zero-extend.
  - 010 lw and all other codes: full word; offset ignored.
- Latency: an instruction captured at edge N writes the register file at edge N+1. The bypass makes its value visible to decode during cycle N..N+1.
- Bypass, combinational, per port i:
  - fwd_rdi = rf_wd if rf_we & (rf_wa == id_rai) & (id_rai != 0); else rf_rdi.
  - ra==0 always returns rf_rdi.
- Simultaneous flush & ex_valid, !stall: the bubble is captured; no write.

Optional Feature:
- Macro WB_BYPASS_EN.
  - Defined: bypass as above.
  - Undefined: fwd_rd1 = rf_rd1 and fwd_rd2 = rf_rd2 unconditionally. The hazard unit must stall one extra cycle on read-after-write. All other behaviour is unchanged.

Decomposition:
- Shared package:
  - WBSEL_ALU/LOAD/PC4 encodings.
  - LOAD funct3 constants (LB, LH, LW, LBU, LHU).
  - XLEN default.
- One natural sub-module: load_align (combinational: dmem_rdata, offset, funct3 -> 32-bit result), reusable by a future store/load unit.

Test Plan:
- Reset, then ALU capture:
  - Assert rst mid-run -> rf_we=0, rf_wa=0, wb_retire=0 immediately.
  - Then capture ex_rd=5, wbsel=00, alu=0x1234 -> next cycle rf_we=1, rf_wa=5, rf_wd=0x1234, wb_retire=1.
- Loads:
  - dmem_rdata=0x80FF7F01, offset 1, lb -> rf_wd=0x0000007F.
  - Same data, offset 2, lb -> 0xFFFFFFFF.
  - Same data, offset 3, lbu -> 0x00000080.
  - Same data, offset 2, lh -> 0xFFFF80FF.
- Stall of 3 cycles after capture of rd=7: rf_we high in the first cycle only; wb_retire pulses once; rf_wa stays 7.
- flush with ex_valid=1 -> no rf_we next cycle. Same with stall=1 also asserted -> prior instruction retained.
- Bypass:
  - rd=9 value 0xDEAD in writeback with id_ra1=9, rf_rd1=0 -> fwd_rd1=0xDEAD.
  - id_ra2=0 -> fwd_rd2=rf_rd2.
  - Without WB_BYPASS_EN -> fwd_rd1=0.
- x0 writes:
  - ex_rd=0, regwrite=1 -> rf_we stays 0.
  - wbsel=10, pc4=0x104 to rd=1 -> rf_wd=0x104.
